// File: rtl/out_port.sv
// Output port stage: FWFT FIFO between the stage-3 output register and an external valid/ack
// consumer. Optional per-entry even parity when OUT_PORT_PARITY_EN is defined.
module out_port #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              dataoutvx3,
  input  logic [DATA_W-1:0] dataoutx3,
  output logic              stalled,
  output logic              dataoutv,
  output logic [DATA_W-1:0] dataout,
`ifdef OUT_PORT_PARITY_EN
  output logic              dataoutp,
`endif
  input  logic              dataoutack,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q, head_d;
  logic              ovf_q;
  logic              full, pop, push_ok, head_is_new;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop     = (count_q != '0) && dataoutack;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_ok = dataoutvx3 && (!full || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign wptr_d = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
  assign rptr_d = pop ? rptr_q + PTR_W'(1) : rptr_q;

  // The head register is loaded with the next head word; if that word is the one being
  // written right now, take it from the input since storage has not been updated yet.
  assign head_is_new = push_ok && (wptr_q == rptr_d);
  assign head_d      = head_is_new ? dataoutx3 : mem_q[rptr_d];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wptr_q] <= dataoutx3;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      if (count_d != '0) begin
        dout_q <= head_d;
      end
      if (dataoutvx3 && !push_ok) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef OUT_PORT_PARITY_EN
  logic par_mem_q [DEPTH];
  logic par_q, par_d;

  assign par_d = head_is_new ? ^dataoutx3 : par_mem_q[rptr_d];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      par_mem_q[wptr_q] <= ^dataoutx3;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      par_q <= 1'b0;
    end else if (count_d != '0) begin
      par_q <= par_d;
    end
  end

  assign dataoutp = par_q;
`endif

  // Two slots stay free for words already in flight through the stage-3 register.
  assign stalled  = (count_q >= CNT_W'(DEPTH - 2));
  assign dataoutv = (count_q != '0);
  assign dataout  = dout_q;
  assign count    = count_q;
  assign ovf      = ovf_q;

endmodule

// File: doc/out_port.md
# out_port

Output port stage directly downstream of the stage-3 output register. Accepts each valid word from `dataoutx3`/`dataoutvx3` into a small first-word-fall-through FIFO and presents it to the external consumer over a valid/ack handshake. Drives `stalled` back into the output register stage when the buffer nears full. Detects words lost to overflow and keeps a sticky flag.

## Interface
- `DATA_W`, 16: width of `t_data` words.
- `DEPTH`, 4: FIFO entries; power of two, at least 4.
- `clock` in 1: single clock; all state updates on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `dataoutvx3` in 1: stage-3 word valid.
- `dataoutx3` in DATA_W: stage-3 word.
- `stalled` out 1: backpressure to the output register stage.
- `dataoutv` out 1: head word valid to the external consumer.
- `dataout` out DATA_W: head word.
- `dataoutack` in 1: consumer accepts the head word this cycle.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `ovf` out 1: sticky overflow flag.
- `dataoutp` out 1: parity of `dataout`; present only with `OUT_PORT_PARITY_EN`.

## Operation
- Push: `dataoutvx3`=1. Pop: `dataoutv`=1 and `dataoutack`=1.
- Push when `count` < DEPTH: word written at the write pointer; wptr increments.
- Push when `count` = DEPTH:
  - with a same-cycle pop: accepted; `count` unchanged.
  - without a pop: word dropped; `ovf` set to 1.
- Pop: rptr increments. `dataoutack` while `dataoutv`=0 is ignored.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
- `count` update: +1 on push only, -1 on pop only, unchanged on both or neither.
- `dataoutv` = (`count` != 0).
- `dataout` = entry at rptr; hold last value when empty.
- `stalled` = (`count` >= DEPTH-2), decoded combinationally from registered `count`. This reserves two slots for words already in flight through the stage-3 register.
- `ovf` is cleared only by reset.
- Word order is strictly preserved.
- No bypass: a word pushed into an empty FIFO is visible the next cycle.

## Timing
- Reset (`resetn`=0, any time, asynchronous):
  - `count`=0, pointers=0, `dataoutv`=0, `dataout`=0, `stalled`=0, `ovf`=0, `dataoutp`=0.
  - Storage contents are don't-care.
  - A push or pop in the reset cycle is lost.
- Latency: push on edge N gives `dataoutv`=1 after edge N, visible in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- `stalled` changes in the cycle after the `count` change that crosses the threshold.
- All outputs are glitch-free functions of registers; no combinational path from `dataoutack` or `dataoutvx3` to any output.

## Configuration
- `OUT_PORT_PARITY_EN` defined:
  - each entry stores an extra even-parity bit, XOR of the word, computed at push;
  - `dataoutp` is driven from the head entry.
- `OUT_PORT_PARITY_EN` undefined: no parity storage, no `dataoutp` port.
- All other behaviour is identical in both builds.

## Test plan
- Reset mid-stream with `count`=3 -> all outputs 0 immediately; after release, the next push of 0x1234 appears alone at `dataout`.
- Single push 0x00A5 with `dataoutack`=0:
  - next cycle `dataoutv`=1, `dataout`=0x00A5, `count`=1;
  - ack one cycle -> `dataoutv`=0, `count`=0.
- DEPTH=4, `dataoutack`=0, push 0x0001..0x0005 on consecutive cycles:
  - `stalled`=1 from the cycle after `count` reaches 2;
  - `count` stops at 4; 0x0005 dropped; `ovf`=1;
  - acks then drain 0x0001..0x0004 in order.
- Full FIFO with simultaneous push 0x00FF and ack -> `count` stays 4, `ovf` stays 0, 0x00FF emerges fourth.
- 100 back-to-back pushes with `dataoutack`=1 held -> one word out per cycle, `stalled` never 1, `count` ≤ 1.
- With `OUT_PORT_PARITY_EN`: push 0x0007 then 0x0003 -> `dataoutp`=1 then 0.
